// File: rtl/imem_encoder_if.sv
// imem_encoder_if: request, memory-write and status signals of the instruction encoder
interface imem_encoder_if #(parameter int AW = 10);
    logic          in_valid;
    logic          in_ready;
    logic          restart;
    logic [4:0]    mnem;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [4:0]    shamt;
    logic [5:0]    funct;
    logic [15:0]   imm;
    logic [25:0]   target;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          err_illegal;
    logic          err_full;
    logic [AW:0]   count;
    modport master (
        output in_valid, restart, mnem, rs, rt, rd, shamt, funct, imm, target,
        input  in_ready, imem_we, imem_addr, imem_wdata, err_illegal, err_full, count
    );
    modport slave (
        input  in_valid, restart, mnem, rs, rt, rd, shamt, funct, imm, target,
        output in_ready, imem_we, imem_addr, imem_wdata, err_illegal, err_full, count
    );
endinterface

// File: rtl/imem_encoder.sv
// imem_encoder: encodes MIPS instruction requests and writes them sequentially into instruction memory
module imem_encoder #(
    parameter int AW = 10
) (
    input logic            clk,
    input logic            rst,
    imem_encoder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;
    state_t        state, nxt;
    logic [AW-1:0] addr;
    logic [AW:0]   cnt;
    logic [31:0]   word;
    logic [31:0]   enc;
    logic [5:0]    op;
    logic          err_ill;
    logic          accept;
    logic          illegal;
    assign illegal = bus.mnem > 5'd20;
    // opcode lookup and field packing for the selected instruction format
    always_comb begin
        op = 6'h00;
        case (bus.mnem)
            5'd1:           op = 6'h09;
            5'd2:           op = 6'h04;
            5'd3:           op = 6'h05;
            5'd4:           op = 6'h23;
            5'd5:           op = 6'h2B;
            5'd6:           op = 6'h0F;
            5'd7:           op = 6'h0A;
            5'd8:           op = 6'h0B;
            5'd9:           op = 6'h0C;
            5'd10:          op = 6'h0D;
            5'd11:          op = 6'h0E;
            5'd12:          op = 6'h28;
            5'd13:          op = 6'h20;
            5'd14:          op = 6'h24;
            5'd15:          op = 6'h02;
            5'd16:          op = 6'h03;
            5'd17, 5'd18:   op = 6'h01;
            5'd19:          op = 6'h07;
            5'd20:          op = 6'h06;
            default:        op = 6'h00;
        endcase
        enc = bus.mnem == 5'd0 ? {6'h00, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct} :
              (bus.mnem == 5'd15 || bus.mnem == 5'd16) ? {op, bus.target} :
              bus.mnem == 5'd17 ? {op, bus.rs, 5'd1, bus.imm} :
              bus.mnem >= 5'd18 ? {op, bus.rs, 5'd0, bus.imm} :
              {op, bus.mnem == 5'd6 ? 5'd0 : bus.rs, bus.rt, bus.imm};
    end
    // next state and interface outputs; restart always returns to IDLE, after finishing a write in progress
    always_comb begin
        accept          = bus.in_valid && state == IDLE && !bus.restart;
        nxt             = bus.restart ? IDLE :
                          state == WRITE ? (&addr ? FULL : IDLE) :
                          state == FULL ? FULL :
                          (accept && !illegal) ? WRITE : IDLE;
        bus.in_ready    = state == IDLE;
        bus.imem_we     = state == WRITE;
        bus.imem_addr   = addr;
        bus.imem_wdata  = state == WRITE ? word : 32'h0;
        bus.err_illegal = err_ill;
        bus.err_full    = state == FULL;
        bus.count       = cnt;
    end
    // state register, captured word, write address and word count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            addr    <= '0;
            cnt     <= '0;
            word    <= '0;
            err_ill <= 1'b0;
        end else begin
            state   <= nxt;
            err_ill <= accept && illegal;
            if (accept && !illegal) word <= enc;
            if (bus.restart) begin
                addr <= '0;
                cnt  <= '0;
            end else if (state == WRITE) begin
                addr <= addr + 1'b1;
                cnt  <= cnt + 1'b1;
            end
        end
    end
endmodule
